// File: rtl/better_neighbor_count.sv
// Scans a block of neighbor costs in cost memory and counts those better than the current cost.
// Optional build macro BNC_EQUAL_IS_BETTER_EN: equal cost also counts as better.
module better_neighbor_count (
  input  logic        clock,
  input  logic        nrst,
  input  logic        start_better_count,
  input  logic [15:0] current_cost,
  input  logic [15:0] neighbor_total,
  input  logic [15:0] base_addr,
  output logic        mem_rd_en,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  output logic [15:0] betterNeighborCount,
  output logic        done_better_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q;
  logic [15:0] cost_q;
  logic [15:0] total_q;
  logic [15:0] base_q;
  logic [15:0] idx_q;
  logic [15:0] count_q;
  logic [15:0] addr_q;
  logic        rd_en_q;
  logic        rd_valid_q;
  logic        done_q;

  logic        is_better;
  logic [15:0] idx_d;
  logic [15:0] count_d;

`ifdef BNC_EQUAL_IS_BETTER_EN
  assign is_better = (mem_data <= cost_q);
`else
  assign is_better = (mem_data < cost_q);
`endif

  // rd_valid_q marks the cycle in which mem_data answers the previous strobe
  assign idx_d   = idx_q + 16'd1;
  assign count_d = count_q + {15'd0, rd_valid_q & is_better};

  // Read 0 is issued on the accepting edge, so idx_q holds the next index to issue
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      cost_q     <= 16'd0;
      total_q    <= 16'd0;
      base_q     <= 16'd0;
      idx_q      <= 16'd0;
      count_q    <= 16'd0;
      addr_q     <= 16'd0;
      rd_en_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_q;
      case (state_q)
        IDLE, DONE: begin
          if (start_better_count) begin
            cost_q  <= current_cost;
            total_q <= neighbor_total;
            base_q  <= base_addr;
            count_q <= 16'd0;
            if (neighbor_total == 16'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              idx_q   <= 16'd0;
            end else begin
              state_q <= SCAN;
              done_q  <= 1'b0;
              rd_en_q <= 1'b1;
              addr_q  <= base_addr;
              idx_q   <= 16'd1;
            end
          end
        end
        SCAN: begin
          count_q <= count_d;
          if (idx_q == total_q) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            addr_q <= base_q + idx_q;
            idx_q  <= idx_d;
          end
        end
        DRAIN: begin
          count_q <= count_d;
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          rd_en_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd_en           = rd_en_q;
  assign mem_addr            = addr_q;
  assign betterNeighborCount = count_q;
  assign done_better_count   = done_q;

endmodule
